// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver: the receiver state set and the frame data width.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_core_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized line, LSB-first shift,
// stop-bit check, and a one-entry valid/ready holding register with error pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 86
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   output logic [7:0] rdata,
   output logic       rvalid,
   input  logic       rready,
   output logic       ferr,
   output logic       overrun,
   output logic       busy
);

   localparam int FULL_BIT = 2 * CLK_PER_HALF_BIT;
   localparam int CW       = $clog2(FULL_BIT);
   localparam int IW       = $clog2(UART_DATA_BITS);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(FULL_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);

   state_t state;
   state_t state_nxt;

   logic                      rxd_s;
   logic [CW-1:0]             cnt;
   logic [IW-1:0]             bit_idx;
   logic [UART_DATA_BITS-1:0] shift;

   logic half_done;
   logic bit_done;
   logic cnt_clr;
   logic idx_clr;
   logic shift_en;
   logic deliver;
   logic frame_err;

   sync2 #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk (clk),
      .rstn(rstn),
      .d   (rxd),
      .q   (rxd_s)
   );

   assign half_done = (cnt == HALF_LAST);
   assign bit_done  = (cnt == FULL_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!rxd_s) state_nxt = START;
         end
         START: begin
            if (half_done) state_nxt = rxd_s ? IDLE : DATA;
         end
         DATA: begin
            if (bit_done && (bit_idx == IDX_LAST)) state_nxt = STOP;
         end
         STOP: begin
            if (bit_done) state_nxt = rxd_s ? IDLE : BRK;
         end
         BRK: begin
            if (rxd_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The counter free-runs only while timing a half or full bit; it is held at zero otherwise.
   always_comb begin
      busy      = (state != IDLE);
      cnt_clr   = 1'b1;
      idx_clr   = 1'b0;
      shift_en  = 1'b0;
      deliver   = 1'b0;
      frame_err = 1'b0;
      case (state)
         START: begin
            cnt_clr = half_done;
            idx_clr = 1'b1;
         end
         DATA: begin
            cnt_clr  = bit_done;
            shift_en = bit_done;
         end
         STOP: begin
            cnt_clr   = bit_done;
            deliver   = bit_done & rxd_s;
            frame_err = bit_done & ~rxd_s;
         end
         default: begin
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         rdata   <= '0;
         rvalid  <= 1'b0;
         ferr    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (cnt_clr) cnt <= '0;
         else         cnt <= cnt + CW'(1);

         if (idx_clr) begin
            bit_idx <= '0;
         end else if (shift_en) begin
            shift[bit_idx] <= rxd_s;
            bit_idx        <= bit_idx + IW'(1);
         end

         ferr    <= frame_err;
         overrun <= deliver & rvalid & ~rready;

         // A byte arriving while the consumer drains the old one replaces it without a gap.
         if (deliver && (!rvalid || rready)) begin
            rdata  <= shift;
            rvalid <= 1'b1;
         end else if (rvalid && rready && !deliver) begin
            rvalid <= 1'b0;
         end
      end
   end

endmodule
